voice_mixer: RTL and testbench

//  Downstream of the per-pad wave players. Each player drives a sample ROM from its address/playing

---
 rtl/audio_pkg.sv | 49 ++++
 rtl/voice_mixer_if.sv | 39 +++
 rtl/mix_tick_gen.sv | 41 ++++
 rtl/voice_mixer.sv | 175 +++++++++++++++++
 tb/tb_voice_mixer.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : audio_pkg                                                       |
// | Purpose  : Shared constants, mixer state encoding and the saturation       |
// |            helper used by the voice mixer.                                 |
// | Contents : DEF_SAMPLE_W, DEF_TICK_DIV, mix_state_e, sat_res_t,             |
// |            sat_to_sample()                                                 |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package audio_pkg;

   // Default sample width and clock cycles per audio sample (50 MHz / 44.1 kHz).
   localparam int DEF_SAMPLE_W = 16;
   localparam int DEF_TICK_DIV = 1134;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      VOL   = 2'd2,
      SAT   = 2'd3
   } mix_state_e;

   // value holds the clamped result sign-extended to 32 bits.
   typedef struct packed {
      logic        clipped;
      logic [31:0] value;
   } sat_res_t;

   // Clamp a signed accumulator to the range of a sw-bit two's-complement sample.
   function automatic sat_res_t sat_to_sample(input logic signed [31:0] acc, input int sw);
      logic signed [31:0] max_v;
      logic signed [31:0] min_v;
      sat_res_t           r;
      max_v = (32'sd1 <<< (sw - 1)) - 32'sd1;
      min_v = -(32'sd1 <<< (sw - 1));
      r.clipped = 1'b1;
      if (acc > max_v) begin
         r.value = max_v;
      end else if (acc < min_v) begin
         r.value = min_v;
      end else begin
         r.value   = acc;
         r.clipped = 1'b0;
      end
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/voice_mixer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : voice_mixer_if                                                  |
// | Purpose  : Mixed-sample handshake bus from the mixer to the DAC side.      |
// | Ports    : mix_sample  mixed sample (master -> slave)                      |
// |            mix_valid   sample available (master -> slave)                  |
// |            mix_ready   consumer accepts (slave -> master)                  |
// |            mix_clip    saturation pulse (master -> slave)                  |
// |            mix_overrun overwrite pulse (master -> slave)                   |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface voice_mixer_if
   import audio_pkg::*;
#(
   parameter int SAMPLE_W = DEF_SAMPLE_W
);
   logic [SAMPLE_W-1:0] mix_sample;
   logic                mix_valid;
   logic                mix_ready;
   logic                mix_clip;
   logic                mix_overrun;

   modport master (
      output mix_sample,
      output mix_valid,
      output mix_clip,
      output mix_overrun,
      input  mix_ready
   );

   modport slave (
      input  mix_sample,
      input  mix_valid,
      input  mix_clip,
      input  mix_overrun,
      output mix_ready
   );
endinterface
`default_nettype wire

// File: rtl/mix_tick_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mix_tick_gen                                                    |
// | Purpose  : Free-running 0..TICK_DIV-1 counter; strobes sample_tick in the  |
// |            cycle the count reaches TICK_DIV-1.                             |
// | Ports    : clock        system clock                                       |
// |            reset        synchronous, active-low                            |
// |            sample_tick  1-cycle strobe every TICK_DIV cycles               |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mix_tick_gen #(
   parameter int TICK_DIV = 1134
) (
   input  logic clock,
   input  logic reset,
   output logic sample_tick
);
   localparam int CNT_W = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TICK_DIV - 1);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q == C_LAST) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign sample_tick = (cnt_q == C_LAST);
endmodule
`default_nettype wire

// File: rtl/voice_mixer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : voice_mixer                                                     |
// | Purpose  : Sums the ROM samples of all playing voices once per audio       |
// |            sample period, saturates the sum and presents it on a           |
// |            valid/ready bus. Also generates the player advance strobe.      |
// | Ports    : clock, reset      system clock, sync active-low reset           |
// |            voice_sample      packed per-voice sample words                 |
// |            voice_playing     per-voice enable                              |
// |            master_volume     8-bit gain (only with MIXER_VOLUME_EN)        |
// |            sample_tick       per-sample strobe                             |
// |            mix_if            master side of the mixed-sample bus           |
// | Config   : MIXER_VOLUME_EN adds master_volume and a scaling state.         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module voice_mixer
   import audio_pkg::*;
#(
   parameter int NUM_VOICES = 4,
   parameter int SAMPLE_W   = DEF_SAMPLE_W,
   parameter int TICK_DIV   = DEF_TICK_DIV
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
   input  logic [NUM_VOICES-1:0]          voice_playing,
`ifdef MIXER_VOLUME_EN
   input  logic [7:0]                     master_volume,
`endif
   output logic                           sample_tick,
   voice_mixer_if.master                  mix_if
);
   localparam int IDX_W = $clog2(NUM_VOICES);
   localparam int ACC_W = SAMPLE_W + IDX_W;

   localparam logic [1:0] ST_IDLE  = IDLE;
   localparam logic [1:0] ST_ACCUM = ACCUM;
`ifdef MIXER_VOLUME_EN
   localparam logic [1:0] ST_VOL   = VOL;
`endif
   localparam logic [1:0] ST_SAT   = SAT;

   localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NUM_VOICES - 1);

   logic [1:0]              state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [SAMPLE_W-1:0]     sample_q, sample_d;
   logic                    valid_q, valid_d;
   logic                    clip_q, clip_d;
   logic                    over_q, over_d;

   logic signed [SAMPLE_W-1:0] voice_w [NUM_VOICES];
   logic signed [ACC_W-1:0]    term_w;
   logic                       load_w;
   logic                       xfer_w;
   sat_res_t                   sat_w;

   mix_tick_gen #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clock       (clock),
      .reset       (reset),
      .sample_tick (sample_tick)
   );

   genvar gi;
   generate
      for (gi = 0; gi < NUM_VOICES; gi++) begin : g_voice
         assign voice_w[gi] = voice_sample[gi*SAMPLE_W +: SAMPLE_W];
      end
   endgenerate

   // Voice idx_q is read in its own ACCUM cycle; silent voices add zero.
   always_comb begin
      term_w = '0;
      if (voice_playing[idx_q]) begin
         term_w = ACC_W'(voice_w[idx_q]);
      end
   end

`ifdef MIXER_VOLUME_EN
   // Gain is (volume+1)/256 so 255 is unity; product is wide enough for 256x.
   logic signed [9:0]       gain_w;
   logic signed [ACC_W+9:0] prod_w;
   assign gain_w = $signed({1'b0, 9'(master_volume) + 9'd1});
   assign prod_w = acc_q * gain_w;
`endif

   assign sat_w = sat_to_sample(32'(acc_q), SAMPLE_W);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      acc_d   = acc_q;
      load_w  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (sample_tick) begin
               state_d = ST_ACCUM;
               idx_d   = '0;
            end
         end
         ST_ACCUM: begin
            acc_d = (idx_q == '0) ? term_w : acc_q + term_w;
            if (idx_q == C_LAST_IDX) begin
`ifdef MIXER_VOLUME_EN
               state_d = ST_VOL;
`else
               state_d = ST_SAT;
`endif
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
`ifdef MIXER_VOLUME_EN
         ST_VOL: begin
            acc_d   = ACC_W'(prod_w >>> 8);
            state_d = ST_SAT;
         end
`endif
         ST_SAT: begin
            load_w  = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // A load coinciding with a transfer hands over the old value and keeps
   // valid high with the new one, so it is not counted as an overrun.
   always_comb begin
      xfer_w   = valid_q & mix_if.mix_ready;
      sample_d = sample_q;
      valid_d  = valid_q;
      clip_d   = 1'b0;
      over_d   = 1'b0;
      if (load_w) begin
         sample_d = SAMPLE_W'(sat_w.value);
         valid_d  = 1'b1;
         clip_d   = sat_w.clipped;
         over_d   = valid_q & ~xfer_w;
      end else if (xfer_w) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         acc_q    <= '0;
         sample_q <= '0;
         valid_q  <= 1'b0;
         clip_q   <= 1'b0;
         over_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         acc_q    <= acc_d;
         sample_q <= sample_d;
         valid_q  <= valid_d;
         clip_q   <= clip_d;
         over_q   <= over_d;
      end
   end

   assign mix_if.mix_sample  = sample_q;
   assign mix_if.mix_valid   = valid_q;
   assign mix_if.mix_clip    = clip_q;
   assign mix_if.mix_overrun = over_q;
endmodule
`default_nettype wire

// File: tb/tb_voice_mixer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_voice_mixer                                                  |
// | Purpose  : Self-checking bench for voice_mixer with a per-cycle            |
// |            behavioural model plus directed literal scenarios.              |
// | Config   : MIXER_VOLUME_EN selects the volume build.                       |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_voice_mixer;
   localparam int N  = 4;
   localparam int SW = 16;
   localparam int TD = 16;
`ifdef MIXER_VOLUME_EN
   localparam int LAT = N + 3;
`else
   localparam int LAT = N + 2;
`endif

   logic            clock = 1'b0;
   logic            reset = 1'b0;
   logic [N*SW-1:0] voice_sample = '0;
   logic [N-1:0]    voice_playing = '0;
   logic            sample_tick;
`ifdef MIXER_VOLUME_EN
   logic [7:0]      master_volume = 8'd255;
`endif

   voice_mixer_if #(.SAMPLE_W(SW)) mif ();

   voice_mixer #(
      .NUM_VOICES (N),
      .SAMPLE_W   (SW),
      .TICK_DIV   (TD)
   ) dut (
      .clock         (clock),
      .reset         (reset),
      .voice_sample  (voice_sample),
      .voice_playing (voice_playing),
`ifdef MIXER_VOLUME_EN
      .master_volume (master_volume),
`endif
      .sample_tick   (sample_tick),
      .mix_if        (mif.master)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string nm, input logic signed [31:0] act,
                        input logic signed [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual %0d required %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // age = cycles since the last reset edge; a tick falls where age mod TD = TD-1.
   // A tick at age t sums voice k as seen at age t+1+k and the result is
   // visible from age t+LAT.
   bit              model_ok = 1'b0;
   int              age = 0;
   int              mix_t = -1;
   int              acc = 0;
   bit              e_valid = 1'b0, e_clip = 1'b0, e_over = 1'b0;
   int              e_sample = 0;
   bit              m_tick, m_ld, m_xfer, m_clip;
   int              m_k, m_val;
   logic signed [SW-1:0] m_vs;

   always @(negedge clock) begin
      m_tick = ((age % TD) == TD - 1);
      if (model_ok) begin
         check("sample_tick", 32'(sample_tick), 32'(m_tick));
         check("mix_valid", 32'(mif.mix_valid), 32'(e_valid));
         check("mix_sample", $signed(mif.mix_sample), e_sample);
         check("mix_clip", 32'(mif.mix_clip), 32'(e_clip));
         check("mix_overrun", 32'(mif.mix_overrun), 32'(e_over));
      end
      if (!reset) begin
         model_ok = 1'b1;
         age = 0; mix_t = -1; acc = 0;
         e_valid = 1'b0; e_sample = 0; e_clip = 1'b0; e_over = 1'b0;
      end else begin
         m_ld = 1'b0; m_val = 0; m_clip = 1'b0;
         if (mix_t >= 0) begin
            m_k = age - mix_t - 1;
            if (m_k >= 0 && m_k < N && voice_playing[m_k]) begin
               m_vs = voice_sample[m_k*SW +: SW];
               acc += int'(m_vs);
            end
`ifdef MIXER_VOLUME_EN
            if (age == mix_t + N + 1) acc = (acc * (int'(master_volume) + 1)) >>> 8;
`endif
            if (age == mix_t + LAT - 1) begin
               m_ld = 1'b1;
               if (acc > 32767)       begin m_val = 32767;  m_clip = 1'b1; end
               else if (acc < -32768) begin m_val = -32768; m_clip = 1'b1; end
               else                         m_val = acc;
               mix_t = -1;
            end
         end
         if (m_tick) begin mix_t = age; acc = 0; end
         m_xfer = e_valid && mif.mix_ready;
         e_clip = 1'b0; e_over = 1'b0;
         if (m_ld) begin
            e_over = e_valid && !m_xfer;
            e_valid = 1'b1; e_sample = m_val; e_clip = m_clip;
         end else if (m_xfer) begin
            e_valid = 1'b0;
         end
         age++;
      end
   end

   // ---------------- directed scenarios ----------------
   task automatic drive(input logic [N-1:0] play, input int v0, input int v1,
                        input int v2, input int v3, input bit rdy);
      @(posedge clock); #2;
      voice_playing = play;
      voice_sample  = {16'(v3), 16'(v2), 16'(v1), 16'(v0)};
      mif.mix_ready = rdy;
   endtask

   // Returns at the negedge of the tick cycle; n = negedges waited.
   task automatic wait_tick(output int n);
      @(negedge clock);
      n = 1;
      while (!sample_tick && n < 64) begin
         @(negedge clock);
         n++;
      end
      if (!sample_tick) check("tick_timeout", 32'(0), 32'(1));
   endtask

   task automatic check_out(input string nm, input int v, input int s,
                            input int c, input int o);
      check({nm, "_valid"}, 32'(mif.mix_valid), v);
      check({nm, "_sample"}, $signed(mif.mix_sample), s);
      check({nm, "_clip"}, 32'(mif.mix_clip), c);
      check({nm, "_overrun"}, 32'(mif.mix_overrun), o);
   endtask

   initial begin
      int n, n2;
      mif.mix_ready = 1'b1;
      reset = 1'b0;
      repeat (3) @(posedge clock);
      #2 reset = 1'b1;
      @(negedge clock);
      check_out("reset", 0, 0, 0, 0);
      check("reset_tick", 32'(sample_tick), 32'(0));
      wait_tick(n);
      check("first_tick_gap", n, 15);

      // single voice passes through
      drive(4'b0001, 1000, 9, 9, 9, 1'b1);
      wait_tick(n);
      repeat (LAT) @(negedge clock);
      check_out("single", 1, 1000, 0, 0);
      @(negedge clock);
      check("single_taken", 32'(mif.mix_valid), 32'(0));

      // positive and negative saturation
      drive(4'b1111, 'h7000, 'h7000, 'h7000, 'h7000, 1'b1);
      wait_tick(n);
      repeat (LAT) @(negedge clock);
      check_out("satpos", 1, 32767, 1, 0);
      drive(4'b1111, 'h9000, 'h9000, 'h9000, 'h9000, 1'b1);
      wait_tick(n);
      repeat (LAT) @(negedge clock);
      check_out("satneg", 1, -32768, 1, 0);

      // overrun with consumer stalled across two ticks
      drive(4'b0001, 111, 0, 0, 0, 1'b0);
      wait_tick(n);
      repeat (LAT) @(negedge clock);
      check_out("ovr_first", 1, 111, 0, 0);
      drive(4'b0001, 222, 0, 0, 0, 1'b0);
      wait_tick(n);
      repeat (LAT) @(negedge clock);
      check_out("ovr_second", 1, 222, 0, 1);
      @(negedge clock);
      check_out("ovr_after", 1, 222, 0, 0);

      // idle voices give zero; tick period
      drive(4'b0000, 5, 6, 7, 8, 1'b1);
      wait_tick(n);
      wait_tick(n2);
      check("tick_period", n2, 16);
      repeat (LAT) @(negedge clock);
      check_out("idle", 1, 0, 0, 0);

      // reset in the second ACCUM cycle drops the partial sum
      drive(4'b0001, 500, 0, 0, 0, 1'b1);
      wait_tick(n);
      @(posedge clock); #2;
      @(posedge clock); #2 reset = 1'b0;
      @(posedge clock); #2 reset = 1'b1;
      @(negedge clock);
      check_out("midreset", 0, 0, 0, 0);
      wait_tick(n);
      check("midreset_tick_gap", n, 15);
      repeat (LAT) @(negedge clock);
      check_out("after_reset", 1, 500, 0, 0);

`ifdef MIXER_VOLUME_EN
      drive(4'b0001, 2000, 0, 0, 0, 1'b1);
      master_volume = 8'd127;
      wait_tick(n);
      repeat (LAT) @(negedge clock);
      check_out("vol127", 1, 1000, 0, 0);
      drive(4'b0001, 2000, 0, 0, 0, 1'b1);
      master_volume = 8'd255;
      wait_tick(n);
      repeat (LAT) @(negedge clock);
      check_out("vol255", 1, 2000, 0, 0);
`endif

      // randomized traffic against the model
      for (int c = 0; c < 1500; c++) begin
         @(posedge clock); #2;
         voice_playing = N'($urandom);
         if ($urandom_range(0, 1) == 0)
            voice_sample = {$urandom, $urandom};
         else
            for (int v = 0; v < N; v++)
               voice_sample[v*SW +: SW] = 16'($signed($urandom_range(0, 4000)) - 2000);
         case ((c / 150) % 3)
            0:       mif.mix_ready = ($urandom_range(0, 9) != 0);
            1:       mif.mix_ready = ($urandom_range(0, 1) == 0);
            default: mif.mix_ready = ($urandom_range(0, 19) == 0);
         endcase
`ifdef MIXER_VOLUME_EN
         master_volume = 8'($urandom);
`endif
         reset = ($urandom_range(0, 399) != 0);
      end
      @(posedge clock); #2 reset = 1'b1;
      repeat (3) @(negedge clock);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
